// File: rtl/vga_color_proc.sv
// Unpacks 32-bit video-memory words into 24-bit RGB pixels (8/16/24/32bpp, optional 8bpp CLUT) for the line FIFO.
// Latency: buffer pop to rgb_fifo_wreq is one clock in direct modes; pop to clut_req one clock; clut_ack to wreq one clock.
// Backpressure: rgb_fifo_full blocks direct-mode writes and their pops; the single CLUT write relies on almost-full headroom.
module vga_color_proc #(
    parameter int LFIFO_AW = 9
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        ctrl_ven,
    input  logic [1:0]  ctrl_cd,
    input  logic        ctrl_pc,
    input  logic [31:0] vdat_buffer_di,
    input  logic        vdat_buffer_empty,
    output logic        vdat_buffer_rreq,
    input  logic        rgb_fifo_full,
    output logic        rgb_fifo_wreq,
    output logic [23:0] rgb_fifo_d,
    output logic        clut_req,
    output logic [7:0]  clut_offs,
    input  logic        clut_ack,
    input  logic [23:0] clut_q
);

    // Line FIFO depth is fixed by the surrounding design; it only needs to be a sane width here.
    if (LFIFO_AW < 1) begin : g_lfifo_aw_check
        $error("LFIFO_AW must be at least 1");
    end

    localparam logic [1:0] CD_8  = 2'b00;
    localparam logic [1:0] CD_16 = 2'b01;
    localparam logic [1:0] CD_24 = 2'b10;
    localparam logic [1:0] CD_32 = 2'b11;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // IDLE: no word held; PIX: draining a held word; CLUT: waiting for the lookup result.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PIX,
        ST_CLUT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [23:0] carry_q, carry_d;
    logic [1:0]  pix_idx_q, pix_idx_d;
    logic [1:0]  phase24_q, phase24_d;

    logic        wreq_q;
    rgb_t        rgb_q;
    logic        clut_req_q;
    logic [7:0]  clut_offs_q;

    logic        flush;
    logic        pc8;
    logic [1:0]  last_idx;
    logic        pop;
    logic        emit;
    rgb_t        pix;
    logic        issue;
    logic [7:0]  offs;
    logic        ack_take;

    // Byte select, most-significant byte first.
    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] byte_v;
        case (idx)
            2'd0:    byte_v = w[31:24];
            2'd1:    byte_v = w[23:16];
            2'd2:    byte_v = w[15:8];
            default: byte_v = w[7:0];
        endcase
        return byte_v;
    endfunction

    // Pixel idx of a word in the non-24bpp direct modes.
    function automatic rgb_t direct_pixel(input logic [31:0] w, input logic [1:0] idx,
                                          input logic [1:0] cd);
        rgb_t       p;
        logic [15:0] half;
        logic [7:0]  byte_v;
        half   = idx[0] ? w[15:0] : w[31:16];
        byte_v = sel_byte(w, idx);
        case (cd)
            CD_8:    p = {byte_v, byte_v, byte_v};
            CD_16:   p = {half[15:11], 3'b000, half[10:5], 2'b00, half[4:0], 3'b000};
            default: p = w[23:0];
        endcase
        return p;
    endfunction

    assign flush = !nrst_i || !ctrl_ven;
    assign pc8   = (ctrl_cd == CD_8) && ctrl_pc;

    // Index of the last pixel in a word for the one-word-per-group modes.
    always_comb begin
        last_idx = 2'd0;
        case (ctrl_cd)
            CD_8:    last_idx = 2'd3;
            CD_16:   last_idx = 2'd1;
            CD_32:   last_idx = 2'd0;
            default: last_idx = 2'd0;
        endcase
    end

    // Next-state, pop and emit decisions. A word's first pixel leaves in the cycle it is popped,
    // so a word only stays held while it still has pixels left.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        carry_d   = carry_q;
        pix_idx_d = pix_idx_q;
        phase24_d = phase24_q;
        pop       = 1'b0;
        emit      = 1'b0;
        pix       = '0;
        issue     = 1'b0;
        offs      = 8'h00;
        ack_take  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!vdat_buffer_empty) begin
                    if (ctrl_cd == CD_24) begin
                        // W0 = {P0, P1[23:16]}: P0 goes out now, P1's top byte is carried.
                        if (!rgb_fifo_full) begin
                            pop       = 1'b1;
                            emit      = 1'b1;
                            pix       = vdat_buffer_di[31:8];
                            carry_d   = {16'h0000, vdat_buffer_di[7:0]};
                            phase24_d = 2'd1;
                            state_d   = ST_PIX;
                        end
                    end else if (pc8) begin
                        pop       = 1'b1;
                        issue     = 1'b1;
                        offs      = vdat_buffer_di[31:24];
                        word_d    = vdat_buffer_di;
                        pix_idx_d = 2'd0;
                        state_d   = ST_CLUT;
                    end else if (!rgb_fifo_full) begin
                        pop    = 1'b1;
                        emit   = 1'b1;
                        pix    = direct_pixel(vdat_buffer_di, 2'd0, ctrl_cd);
                        word_d = vdat_buffer_di;
                        if (last_idx == 2'd0) begin
                            pix_idx_d = 2'd0;
                            state_d   = ST_IDLE;
                        end else begin
                            pix_idx_d = 2'd1;
                            state_d   = ST_PIX;
                        end
                    end
                end
            end

            ST_PIX: begin
                if (ctrl_cd == CD_24) begin
                    case (phase24_q)
                        2'd1: begin
                            // P1 spans W0/W1: needs W1 at the head and room downstream.
                            if (!vdat_buffer_empty && !rgb_fifo_full) begin
                                pop       = 1'b1;
                                emit      = 1'b1;
                                pix       = {carry_q[7:0], vdat_buffer_di[31:16]};
                                carry_d   = {8'h00, vdat_buffer_di[15:0]};
                                phase24_d = 2'd2;
                            end
                        end
                        2'd2: begin
                            // P2 spans W1/W2; W2's low three bytes are P3 in full.
                            if (!vdat_buffer_empty && !rgb_fifo_full) begin
                                pop       = 1'b1;
                                emit      = 1'b1;
                                pix       = {carry_q[15:0], vdat_buffer_di[31:24]};
                                carry_d   = vdat_buffer_di[23:0];
                                phase24_d = 2'd3;
                            end
                        end
                        2'd3: begin
                            if (!rgb_fifo_full) begin
                                emit      = 1'b1;
                                pix       = carry_q;
                                phase24_d = 2'd0;
                                state_d   = ST_IDLE;
                            end
                        end
                        default: begin
                            phase24_d = 2'd0;
                            state_d   = ST_IDLE;
                        end
                    endcase
                end else if (pc8) begin
                    issue   = 1'b1;
                    offs    = sel_byte(word_q, pix_idx_q);
                    state_d = ST_CLUT;
                end else if (!rgb_fifo_full) begin
                    emit = 1'b1;
                    pix  = direct_pixel(word_q, pix_idx_q, ctrl_cd);
                    if (pix_idx_q == last_idx) begin
                        pix_idx_d = 2'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        pix_idx_d = pix_idx_q + 2'd1;
                    end
                end
            end

            ST_CLUT: begin
                if (clut_ack) begin
                    ack_take = 1'b1;
                    emit     = 1'b1;
                    pix      = clut_q;
                    if (pix_idx_q == 2'd3) begin
                        pix_idx_d = 2'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        pix_idx_d = pix_idx_q + 2'd1;
                        state_d   = ST_PIX;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset and video-disable both flush everything.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            carry_q     <= '0;
            pix_idx_q   <= '0;
            phase24_q   <= '0;
            wreq_q      <= 1'b0;
            rgb_q       <= '0;
            clut_req_q  <= 1'b0;
            clut_offs_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            carry_q   <= carry_d;
            pix_idx_q <= pix_idx_d;
            phase24_q <= phase24_d;
            wreq_q    <= emit;
            if (emit) begin
                rgb_q <= pix;
            end
            if (issue) begin
                clut_req_q  <= 1'b1;
                clut_offs_q <= offs;
            end else if (ack_take) begin
                clut_req_q  <= 1'b0;
            end
        end
    end

    assign vdat_buffer_rreq = pop && !flush;
    assign rgb_fifo_wreq    = wreq_q;
    assign rgb_fifo_d       = rgb_q;
    assign clut_req         = clut_req_q;
    assign clut_offs        = clut_offs_q;

endmodule

// File: tb/tb_vga_color_proc.sv
// Directed bench for vga_color_proc: buffer and CLUT responders modelled in-line.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected pixels and timing are written out by hand from the packing rules.
module tb_vga_color_proc;

    logic        clk;
    logic        nrst_i;
    logic        ctrl_ven;
    logic [1:0]  ctrl_cd;
    logic        ctrl_pc;
    logic [31:0] vdat_buffer_di;
    logic        vdat_buffer_empty;
    logic        vdat_buffer_rreq;
    logic        rgb_fifo_full;
    logic        rgb_fifo_wreq;
    logic [23:0] rgb_fifo_d;
    logic        clut_req;
    logic [7:0]  clut_offs;
    logic        clut_ack;
    logic [23:0] clut_q;

    always #5 clk = ~clk;

    vga_color_proc #(.LFIFO_AW(9)) dut (
        .clk_i             (clk),
        .nrst_i            (nrst_i),
        .ctrl_ven          (ctrl_ven),
        .ctrl_cd           (ctrl_cd),
        .ctrl_pc           (ctrl_pc),
        .vdat_buffer_di    (vdat_buffer_di),
        .vdat_buffer_empty (vdat_buffer_empty),
        .vdat_buffer_rreq  (vdat_buffer_rreq),
        .rgb_fifo_full     (rgb_fifo_full),
        .rgb_fifo_wreq     (rgb_fifo_wreq),
        .rgb_fifo_d        (rgb_fifo_d),
        .clut_req          (clut_req),
        .clut_offs         (clut_offs),
        .clut_ack          (clut_ack),
        .clut_q            (clut_q)
    );

    localparam int ACK_DLY = 3;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cycle   = 0;

    logic [31:0] vbuf[$];
    logic [23:0] wlog[$];
    int          wcyc[$];
    int          rcyc[$];
    logic [7:0]  olog[$];
    int          ocyc[$];
    int          acyc[$];

    logic        prev_req  = 1'b0;
    logic        clut_auto = 1'b0;
    int          wait_cnt  = 0;

    logic        l_rreq, l_wreq, l_req;
    logic [23:0] l_d;
    logic [7:0]  l_offs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wget(input int i);
        if (i < wlog.size()) return {8'h00, wlog[i]};
        return 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] oget(input int i);
        if (i < olog.size()) return {24'h0, olog[i]};
        return 32'hDEADBEEF;
    endfunction

    function automatic int qi(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1000;
    endfunction

    task automatic refresh_buf();
        vdat_buffer_empty = (vbuf.size() == 0);
        vdat_buffer_di    = (vbuf.size() == 0) ? 32'h0 : vbuf[0];
    endtask

    task automatic push(input logic [31:0] w);
        vbuf.push_back(w);
        refresh_buf();
    endtask

    task automatic clear_logs();
        wlog.delete(); wcyc.delete(); rcyc.delete();
        olog.delete(); ocyc.delete(); acyc.delete();
        wait_cnt = 0;
    endtask

    // One clock: sample on the falling edge, then update buffer and CLUT responder after the rising edge.
    task automatic cyc();
        logic s_rreq;
        logic do_ack;
        @(negedge clk);
        cycle++;
        s_rreq = vdat_buffer_rreq;
        l_rreq = vdat_buffer_rreq;
        l_wreq = rgb_fifo_wreq;
        l_req  = clut_req;
        l_d    = rgb_fifo_d;
        l_offs = clut_offs;
        if (s_rreq) rcyc.push_back(cycle);
        if (rgb_fifo_wreq) begin
            wlog.push_back(rgb_fifo_d);
            wcyc.push_back(cycle);
        end
        if (clut_req && !prev_req) begin
            olog.push_back(clut_offs);
            ocyc.push_back(cycle);
        end
        prev_req = clut_req;
        if (clut_auto && clut_req && !clut_ack) wait_cnt++;
        do_ack = clut_auto && (wait_cnt == ACK_DLY);
        @(posedge clk);
        #1;
        if (s_rreq && vbuf.size() > 0) vbuf.delete(0);
        if (clut_auto) begin
            if (do_ack) begin
                clut_ack = 1'b1;
                clut_q   = {3{clut_offs}};
                wait_cnt = 0;
                acyc.push_back(cycle + 1);
            end else begin
                clut_ack = 1'b0;
            end
        end
        refresh_buf();
    endtask

    task automatic set_mode(input logic [1:0] cd, input logic pc);
        ctrl_ven = 1'b0;
        cyc();
        ctrl_cd  = cd;
        ctrl_pc  = pc;
        ctrl_ven = 1'b1;
        clear_logs();
    endtask

    task automatic run_writes(input int n, input int budget);
        for (int i = 0; i < budget && wlog.size() < n; i++) cyc();
    endtask

    initial begin
        clk           = 1'b0;
        nrst_i        = 1'b0;
        ctrl_ven      = 1'b1;
        ctrl_cd       = 2'b11;
        ctrl_pc       = 1'b0;
        rgb_fifo_full = 1'b0;
        clut_ack      = 1'b0;
        clut_q        = 24'h0;
        refresh_buf();
        push(32'h12345678);

        // Reset with a word waiting: nothing popped, all outputs cleared.
        repeat (3) cyc();
        check("rst_rreq", l_rreq, 1'b0);
        check("rst_wreq", l_wreq, 1'b0);
        check("rst_d", l_d, 24'h0);
        check("rst_clut_req", l_req, 1'b0);
        check("rst_clut_offs", l_offs, 8'h0);
        vbuf.delete();
        refresh_buf();
        nrst_i = 1'b1;

        // 32bpp back-to-back words.
        set_mode(2'b11, 1'b0);
        push(32'hAA112233);
        push(32'h00445566);
        run_writes(2, 20);
        repeat (2) cyc();
        check("cd32_nwr", wlog.size(), 2);
        check("cd32_px0", wget(0), 24'h112233);
        check("cd32_px1", wget(1), 24'h445566);
        check("cd32_nrreq", rcyc.size(), 2);
        check("cd32_rreq_b2b", qi(rcyc, 1) - qi(rcyc, 0), 1);
        check("cd32_lat", qi(wcyc, 0) - qi(rcyc, 0), 1);
        check("cd32_wr_b2b", qi(wcyc, 1) - qi(wcyc, 0), 1);

        // 16bpp RGB565 expansion.
        set_mode(2'b01, 1'b0);
        push(32'hF81F07E0);
        run_writes(2, 20);
        repeat (2) cyc();
        check("cd16_nwr", wlog.size(), 2);
        check("cd16_px0", wget(0), 24'hF800F8);
        check("cd16_px1", wget(1), 24'h00FC00);
        check("cd16_wr_b2b", qi(wcyc, 1) - qi(wcyc, 0), 1);

        // 24bpp with the buffer running dry between words.
        set_mode(2'b10, 1'b0);
        push(32'h11223344);
        repeat (6) cyc();
        check("cd24_only_p0", wlog.size(), 1);
        check("cd24_px0", wget(0), 24'h112233);
        push(32'h55667788);
        repeat (4) cyc();
        check("cd24_p1_no_p2", wlog.size(), 2);
        check("cd24_px1", wget(1), 24'h445566);
        push(32'h99AABBCC);
        repeat (5) cyc();
        check("cd24_nwr", wlog.size(), 4);
        check("cd24_px2", wget(2), 24'h778899);
        check("cd24_px3", wget(3), 24'hAABBCC);
        check("cd24_nrreq", rcyc.size(), 3);

        // 8bpp pseudo-colour through a CLUT that answers 3 cycles after each request.
        set_mode(2'b00, 1'b1);
        clut_auto = 1'b1;
        push(32'h01020304);
        run_writes(4, 60);
        repeat (2) cyc();
        clut_auto = 1'b0;
        clut_ack  = 1'b0;
        check("pc_nwr", wlog.size(), 4);
        check("pc_nreq", olog.size(), 4);
        check("pc_req_lat", qi(ocyc, 0) - qi(rcyc, 0), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pc_offs%0d", i), oget(i), 32'(i + 1));
            check($sformatf("pc_px%0d", i), wget(i), 32'((i + 1) * 32'h010101));
            check($sformatf("pc_ack_lat%0d", i), qi(wcyc, i) - qi(acyc, i), 1);
        end
        for (int i = 1; i < 4; i++) begin
            check($sformatf("pc_one_out%0d", i), 32'(qi(ocyc, i) > qi(acyc, i - 1)), 1);
        end

        // 8bpp greyscale under backpressure right after the first pixel.
        set_mode(2'b00, 1'b0);
        push(32'h80FF0010);
        cyc();
        rgb_fifo_full = 1'b1;
        cyc();
        check("bp_first", wlog.size(), 1);
        repeat (4) cyc();
        rgb_fifo_full = 1'b0;
        cyc();
        check("bp_hold", wlog.size(), 1);
        run_writes(4, 20);
        repeat (2) cyc();
        check("bp_nwr", wlog.size(), 4);
        check("bp_px0", wget(0), 24'h808080);
        check("bp_px1", wget(1), 24'hFFFFFF);
        check("bp_px2", wget(2), 24'h000000);
        check("bp_px3", wget(3), 24'h101010);

        // Video disable while a CLUT request is pending, with a late ack.
        set_mode(2'b00, 1'b1);
        push(32'h0A0B0C0D);
        push(32'h21222324);
        for (int i = 0; i < 10 && olog.size() == 0; i++) cyc();
        check("fl_req_seen", l_req, 1'b1);
        check("fl_req_offs", l_offs, 8'h0A);
        ctrl_ven = 1'b0;
        cyc();
        clut_ack = 1'b1;
        clut_q   = 24'hABCDEF;
        cyc();
        check("fl_req_drop", l_req, 1'b0);
        check("fl_wreq", l_wreq, 1'b0);
        check("fl_rreq_gated", l_rreq, 1'b0);
        clut_ack = 1'b0;
        cyc();
        check("fl_late_ack", l_wreq, 1'b0);
        clear_logs();
        ctrl_ven  = 1'b1;
        clut_auto = 1'b1;
        run_writes(1, 30);
        clut_auto = 1'b0;
        clut_ack  = 1'b0;
        check("fl_next_offs", oget(0), 8'h21);
        check("fl_next_px", wget(0), 24'h212121);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_color_proc.md
Name: vga_color_proc

Overview:
- Downstream stage of the VGA Wishbone master.
- Consumes the 32-bit video-memory words that the master's burst reads deposit in the show-ahead video data buffer.
- Unpacks each word into 24-bit RGB pixels according to the colour depth, with an optional CLUT lookup for 8bpp pseudo-colour.
- Writes the pixels into the line FIFO that feeds the pixel generator.

Parameters:
- LFIFO_AW, 9, address width of the line FIFO. Informational only, carried for bind/check symmetry; it does not alter logic.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge
- nrst_i  in  1  reset, synchronous, active-low
- ctrl_ven  in  1  video enable; low acts as a synchronous flush
- ctrl_cd  in  2  colour depth: 00=8bpp, 01=16bpp, 10=24bpp, 11=32bpp
- ctrl_pc  in  1  8bpp pseudo-colour (CLUT) select
- vdat_buffer_di  in  32  head word of the video data buffer, valid while !vdat_buffer_empty
- vdat_buffer_empty  in  1  video data buffer empty
- vdat_buffer_rreq  out  1  pop the head word (combinational, single-cycle)
- rgb_fifo_full  in  1  line FIFO almost-full (high when ≤1 free entry)
- rgb_fifo_wreq  out  1  line FIFO write strobe (registered)
- rgb_fifo_d  out  24  pixel {R,G,B} (registered, valid with wreq)
- clut_req  out  1  CLUT read request (registered, held until ack)
- clut_offs  out  8  CLUT index (stable while clut_req)
- clut_ack  in  1  CLUT read done; clut_q is valid in this cycle
- clut_q  in  24  CLUT data

Behaviour:
- Reset, or ctrl_ven low, at any clock edge:
  - state=IDLE, pix_idx=0, phase24=0, word and carry registers 0.
  - rgb_fifo_wreq=0, rgb_fifo_d=0, clut_req=0, clut_offs=0. vdat_buffer_rreq=0.
  - A clut_ack arriving while flushed or in IDLE is ignored.
  - ctrl_cd and ctrl_pc may change only while ctrl_ven is low. A change while enabled is undefined.
- States: IDLE (no word held), PIX (emitting from held word), CLUT (waiting clut_ack).
- IDLE: if !vdat_buffer_empty, assert rreq, latch di, pix_idx=0, go to PIX.
- PIX, emit rule: a pixel is emitted only when rgb_fifo_full=0. Emitting registers rgb_fifo_wreq=1 and rgb_fifo_d for the next cycle. If full=1, hold with no emission and no pop.
- Pixel order within a word is most-significant first.
- 32bpp: one pixel per word, equal to di[23:0]; di[31:24] is discarded.
- 16bpp (RGB565):
  - Pixels come from word[31:16], then word[15:0].
  - Expansion: R={r5,3'b000}, G={g6,2'b00}, B={b5,3'b000}.
- 8bpp: bytes 31:24, 23:16, 15:8, 7:0 in that order.
  - Greyscale (ctrl_pc=0): pixel = {b,b,b}.
  - Pseudo-colour (ctrl_pc=1): instead of emitting, set clut_req=1 and clut_offs=byte (next cycle), then go to CLUT.
- CLUT state:
  - On clut_ack: clut_req=0, wreq=1, rgb_fifo_d=clut_q (next cycle), then advance.
  - The CLUT path never checks rgb_fifo_full. Almost-full headroom covers this single write.
  - Only one request is outstanding at a time.
- 24bpp: 3 words produce 4 pixels; phase24 cycles 0..3.
  - Packing: W0={P0,P1[23:16]}, W1={P1[15:0],P2[23:8]}, W2={P2[7:0],P3}.
  - A pixel that spans two words is emitted only when the next word is available (!empty) and full=0. That word is popped in the same cycle, and its unused bits are kept in the carry register.
  - If the next word is not available, hold without emitting.
- Advance after the last pixel of a word:
  - If !empty, pop the next word in the same cycle. This gives back-to-back pixels at 1/clk in direct modes.
  - Otherwise go to IDLE.
- Latency:
  - Direct modes: pop at cycle t gives wreq at t+1.
  - Pseudo-colour: pop at t gives clut_req at t+1; ack at cycle a gives wreq at a+1.
- Throughput: at most one rreq per cycle and at most one wreq per cycle.
- Buffer empty mid-word is harmless: the held word continues to drain.

Test Plan:
- 32bpp, words 0xAA112233, 0x00445566 back-to-back, full=0 -> wreq on 2 consecutive cycles with d=0x112233, 0x445566. rreq pulses at t and t+1.
- 16bpp, word 0xF81F07E0 -> d=0xF800F8, then 0x00FC00.
- 24bpp, words 0x11223344, 0x55667788, 0x99AABBCC -> 4 writes: 0x112233, 0x445566, 0x778899, 0xAABBCC. Buffer emptied after W0: P0 emitted, P1 held until W1 arrives.
- 8bpp pseudo-colour, word 0x01020304, clut_ack delayed 3 cycles each, clut_q=index*0x010101 -> clut_offs 01,02,03,04 in order, one request at a time. Writes 0x010101..0x040404, each 1 cycle after its ack.
- Backpressure: 8bpp greyscale, 0x80FF0010, full forced high for 5 cycles after the first pixel -> no wreq while full. Pixels 0x808080, 0xFFFFFF, 0x000000, 0x101010 are written in order with none lost or duplicated.
- ctrl_ven dropped while clut_req=1 -> next cycle clut_req=0 and wreq=0. A late clut_ack produces no write. After re-enable, the first pixel comes from the next buffer word.
